// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared definitions for the multi-read-port register file:
//   - clear-engine FSM state encoding
//   - default parameter values for the top level
//   - slice_lo(): low bit index of port k in a packed multi-port bus
package reg_file_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_N_RD   = 2;

    // Port k of a packed bus with per-port width 'width' starts at this bit.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port
// One registered read port of the register file.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rd_acc        read accepted this cycle (array idle, enabled, strobed)
//   wr_ok         a write is being committed this cycle
//   wr_addr/data  address/data of that write (used for write-first bypass)
//   rd_addr       this port's read address
//   mem           current array contents
//   rd_data       registered read data for this port
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_acc,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem [DEPTH],
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              in_range_s;
    logic              zero_s;
    logic              bypass_s;
    logic [DATA_W-1:0] rd_nxt_s;
    logic [DATA_W-1:0] rd_data_r;

    // Extra leading zero lets DEPTH itself be represented for the compare.
    assign in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    assign zero_s     = ZERO_REG && (rd_addr == {ADDR_W{1'b0}});
    // wr_ok already excludes dropped writes, so a dropped write never bypasses.
    assign bypass_s   = wr_ok && (wr_addr == rd_addr);

    // Select the value this port captures: 0, bypassed write data or array entry.
    always_comb begin
        rd_nxt_s = {DATA_W{1'b0}};
        if (!in_range_s) begin
            rd_nxt_s = {DATA_W{1'b0}};
        end else if (zero_s) begin
            rd_nxt_s = {DATA_W{1'b0}};
        end else if (bypass_s) begin
            rd_nxt_s = wr_data;
        end else begin
            rd_nxt_s = mem[rd_addr];
        end
    end

    // Output register: loads on an accepted read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_acc) begin
            rd_data_r <= rd_nxt_s;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Parametrised register file with N_RD registered read ports, write-first
// bypass, optional hard-wired zero register and a one-entry-per-cycle clear.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  global enable; all state holds when low
//   wr_en/addr/data     write port
//   rd_en               read strobe common to all ports
//   rd_addr             packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data             packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_valid            rd_data was loaded by a read accepted last cycle
//   clr_req             start a clear sweep of the whole array
//   busy                clear sweep in progress
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = DEF_N_RD,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic                   rd_valid,
    input  logic                   clr_req,
    output logic                   busy
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              busy_r;
    logic              rd_valid_r;
    logic              idle_s;
    logic              clr_step_s;
    logic              wr_ok_s;
    logic              rd_acc_s;

    assign idle_s     = (state_r == IDLE);
    assign clr_step_s = (state_r == CLEAR) && en;
    assign rd_acc_s   = idle_s && en && rd_en;

    // Write qualification: idle and enabled, in range, not the zero register.
    always_comb begin
        wr_ok_s = 1'b0;
        if (idle_s && en && wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
            wr_ok_s = !(ZERO_REG && (wr_addr == {ADDR_W{1'b0}}));
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Clear-engine next state and sweep counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (en && clr_req) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                if (!en) begin
                    state_nxt_s = CLEAR;
                end else if (cnt_r == LAST_L) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Clear-engine state, counter and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == CLEAR);
        end
    end

    // Storage array: sweep clear has priority; writes are blocked while busy anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clr_step_s) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // rd_valid: set by an accepted read, cleared by an enabled idle cycle, held when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
        end else if (rd_acc_s) begin
            rd_valid_r <= 1'b1;
        end else if (en) begin
            rd_valid_r <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .clk    (clk),
            .rst    (rst),
            .rd_acc (rd_acc_s),
            .wr_ok  (wr_ok_s),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .rd_addr(rd_addr[slice_lo(k, ADDR_W) +: ADDR_W]),
            .mem    (mem_r),
            .rd_data(rd_data[slice_lo(k, DATA_W) +: DATA_W])
        );
    end

    assign busy     = busy_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file: the successor to the fixed 32x16 two-read-port register file used by the CPU datapath. It adds generic width, depth and read-port count, write-first bypass on same-cycle read/write, an optional hard-wired zero register, and a sequenced clear engine that wipes the array one entry per cycle. It sits between the decode stage and the ALU operand latches.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 16, number of registers (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- N_RD, 2, number of independent read ports (1..8)
- ZERO_REG, 0, when 1 register 0 always reads 0 and writes to it are dropped
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when low all state holds (including clear sweep)
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read strobe, common to all ports
- rd_addr  in  N_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed registered read data, port k at [k*DATA_W +: DATA_W]
- rd_valid  out  1  rd_data updated by a read accepted last cycle
- clr_req  in  1  start a sequenced clear of the whole array
- busy  out  1  clear sweep in progress

## Operation
- Async reset: every register = 0, rd_data = 0, rd_valid = 0, busy = 0, FSM = IDLE, sweep counter = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clk edge with en && clr_req; counter loads 0.
  - CLEAR: each enabled cycle writes 0 to entry [counter], counter += 1; at counter == DEPTH-1 the last entry is cleared and FSM returns to IDLE, counter -> 0.
  - clr_req while busy is ignored (no restart, no queueing).
- Write (IDLE, en, wr_en): array[wr_addr] <= wr_data. Dropped if wr_addr ≥ DEPTH, or ZERO_REG && wr_addr == 0.
- Read (IDLE, en, rd_en): per port k, rd_data[k] <= bypass ? wr_data : array[rd_addr[k]]; rd_valid <= 1.
  - bypass = accepted write this cycle to the same address (write-first). Not taken when the write is dropped.
  - rd_addr ≥ DEPTH returns 0; ZERO_REG && rd_addr == 0 returns 0.
  - Multiple ports may address the same register; all get identical data.
- No read accepted in a cycle (rd_en low, en low, or busy): rd_data holds its previous value; rd_valid <= 0 when en high, holds when en low.
- While busy: wr_en and rd_en ignored entirely; no bypass.
- en low mid-sweep: sweep pauses, busy stays 1, resumes where it left off.
- Reset mid-sweep: immediate full clear, busy drops asynchronously.

## Timing
- Read latency 1 cycle: address at edge N, data and rd_valid valid after edge N+1.
- Write visible to a read in the same cycle (bypass), i.e. also 1 cycle.
- Clear takes exactly DEPTH enabled cycles; busy high from the edge after clr_req through the edge that clears the last entry; first accepted read/write the cycle busy is low.
- No combinational path from inputs to outputs.

## Structure
- Package reg_file_pkg: FSM state enum (IDLE, CLEAR), default parameter constants, helper function for packed-port slice offsets.
- Sub-module reg_file_rd_port: one read port (address range check, zero-register mask, bypass compare, output register); instantiated N_RD times via generate. Array, write logic and clear FSM live in the top.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and read r5 on port 0 next cycle -> rd_data[0] = 0xDEADBEEF, rd_valid = 1 one cycle after the read.
- Same-cycle write 0x1234 to r3 and read r3 on both ports (r3 previously 0xAAAA) -> both ports return 0x1234.
- ZERO_REG=1: write 0xFFFF to r0, read r0 -> 0; DEPTH=12: write addr 13 then read addr 13 -> 0, no other entry changed.
- Fill all entries with nonzero values, pulse clr_req -> busy high exactly DEPTH cycles, writes/reads during sweep ignored, all entries read 0 afterward.
- Start sweep, drop en for 3 cycles at counter 4 -> busy held, sweep resumes at 4, total enabled cycles = DEPTH.
- Assert rst at sweep counter 7 -> busy, rd_valid, rd_data go 0 immediately; all entries read 0 after release; a fresh clr_req starts at entry 0.
